// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
// The gate state enum is shared by both gate FSMs.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPEN   = 3'd1,
    REPORT = 3'd2,
    CLOSE  = 3'd3,
    DENY   = 3'd4
  } gate_state_t;

  localparam int unsigned OPEN_TIMEOUT_DEFAULT = 20;

endpackage : parking_pkg

// File: rtl/parking_gate_fsm.sv
// One gate controller: admits (optionally checking space), holds the barrier
// open until the car passes or the timer expires, then reports the event.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEFAULT,
  parameter bit          CHECK_SPACE  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic is_uni,
  input  logic pass,
  input  logic space_ok,
  input  logic hold_report,
  output logic gate_open,
  output logic car_event,
  output logic car_cls,
  output logic denied,
  output logic timeout
);

  localparam int unsigned     TW         = $clog2(OPEN_TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(OPEN_TIMEOUT - 1);

  gate_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cls_q, cls_d;
  logic          timeout_q, timeout_d;

  // NOTE: reset is sampled on the clock edge; it clears every register,
  // so an aborted transaction leaves no pending pulse behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cls_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // the same pre-edge values regardless of statement order.
      state_q   <= state_d;
      timer_q   <= timer_d;
      cls_q     <= cls_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path infers a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    cls_d     = cls_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cls_d   = is_uni;
          timer_d = '0;
          state_d = (!CHECK_SPACE || space_ok) ? OPEN : DENY;
        end
      end
      DENY: state_d = CLOSE;
      OPEN: begin
        // A pass on the final open cycle still wins over the timeout.
        if (pass) begin
          state_d = REPORT;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = CLOSE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPORT: begin
        if (!hold_report) state_d = CLOSE;
      end
      CLOSE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; hold_report comes from the other gate's state register.
  always_comb begin
    gate_open = (state_q == OPEN);
    car_event = (state_q == REPORT) && !hold_report;
    car_cls   = cls_q;
    denied    = (state_q == DENY);
    timeout   = timeout_q;
  end

endmodule : parking_gate_fsm

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate controller feeding the occupancy counter's event inputs.
// Entry events defer one cycle when they would collide with an exit event.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_req,
  input  logic entry_is_uni,
  input  logic entry_pass,
  input  logic exit_req,
  input  logic exit_is_uni,
  input  logic exit_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_denied,
  output logic entry_timeout,
  output logic exit_timeout
);

  logic entry_space_ok;
  logic entry_event, entry_cls;
  logic exit_event, exit_cls;

  assign entry_space_ok = entry_is_uni ? uni_is_vacated_space : is_vacated_space;

  // The exit gate never holds, so its event pulse equals "exit in REPORT".
  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CHECK_SPACE  (1'b1)
  ) u_entry (
    .clk         (clk),
    .reset       (reset),
    .req         (entry_req),
    .is_uni      (entry_is_uni),
    .pass        (entry_pass),
    .space_ok    (entry_space_ok),
    .hold_report (exit_event),
    .gate_open   (entry_gate_open),
    .car_event   (entry_event),
    .car_cls     (entry_cls),
    .denied      (entry_denied),
    .timeout     (entry_timeout)
  );

  parking_gate_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CHECK_SPACE  (1'b0)
  ) u_exit (
    .clk         (clk),
    .reset       (reset),
    .req         (exit_req),
    .is_uni      (exit_is_uni),
    .pass        (exit_pass),
    .space_ok    (1'b1),
    .hold_report (1'b0),
    .gate_open   (exit_gate_open),
    .car_event   (exit_event),
    .car_cls     (exit_cls),
    .denied      (),
    .timeout     (exit_timeout)
  );

  always_comb begin
    car_entered        = entry_event;
    is_uni_car_entered = entry_event & entry_cls;
    car_exited         = exit_event;
    is_uni_car_exited  = exit_event & exit_cls;
  end

endmodule : parking_gate_ctrl
